axil_slave_regfile: RTL and testbench

AXI4-Lite slave endpoint holding a bank of memory-mapped read/write registers. It terminates one slave port of `axi_lite_interconnect` and is the responder for transactions issued by the picorv32_axi master. Write and read channels are served by independent state machines. Register contents and per-register write pulses are exported to the peripheral logic.

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_addr_check.sv | 24 ++
 rtl/axil_slave_regfile.sv | 192 +++++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, FSM state types and byte-lane merge
package axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                             input logic [7:0] new_byte,
                                             input logic       strb);
      return strb ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/axil_addr_check.sv
// rtl/axil_addr_check.sv - decodes a byte address into a register index and in-range flag
module axil_addr_check #(
   parameter int                    NUM_REGS   = 8,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0001_0000),
   localparam int                   IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [IDX_W-1:0]      idx,
   output logic                  in_range
);

   localparam int                SHIFT = $clog2(DATA_WIDTH / 8);
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(NUM_REGS * (DATA_WIDTH / 8));

   logic [ADDR_WIDTH-1:0] offset;

   // Wrapping subtraction: addresses below the base land far out of range.
   assign offset   = addr - BASE_ADDR;
   assign in_range = {1'b0, offset} < SPAN;
   assign idx      = IDX_W'(offset >> SHIFT);

endmodule

// File: rtl/axil_slave_regfile.sv
// rtl/axil_slave_regfile.sv - AXI4-Lite register bank slave; AXIL_REGFILE_SLVERR_EN enables SLVERR on out-of-range access
module axil_slave_regfile
   import axil_pkg::*;
#(
   parameter int                    NUM_REGS   = 8,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0001_0000),
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [ADDR_WIDTH-1:0]          i_s_axi_awaddr,
   input  logic [2:0]                     i_s_axi_awprot,
   input  logic                           i_s_axi_awvalid,
   output logic                           o_s_axi_awready,
   input  logic [DATA_WIDTH-1:0]          i_s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        i_s_axi_wstrb,
   input  logic                           i_s_axi_wvalid,
   output logic                           o_s_axi_wready,
   output logic [1:0]                     o_s_axi_bresp,
   output logic                           o_s_axi_bvalid,
   input  logic                           i_s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          i_s_axi_araddr,
   input  logic [2:0]                     i_s_axi_arprot,
   input  logic                           i_s_axi_arvalid,
   output logic                           o_s_axi_arready,
   output logic [DATA_WIDTH-1:0]          o_s_axi_rdata,
   output logic [1:0]                     o_s_axi_rresp,
   output logic                           o_s_axi_rvalid,
   input  logic                           i_s_axi_rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
   output logic [NUM_REGS-1:0]            o_wr_pulse
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] OOR_RESP = AXI_RESP_SLVERR;
`else
   localparam logic [1:0] OOR_RESP = AXI_RESP_OKAY;
`endif

   w_state_t              w_state, w_state_nxt;
   r_state_t              r_state, r_state_nxt;
   logic                  ready_en;
   logic                  aw_held, w_held;
   logic [IDX_W-1:0]      aw_idx_q;
   logic                  aw_ok_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;
   logic [IDX_W-1:0]      aw_idx_dec, ar_idx_dec;
   logic                  aw_ok_dec, ar_ok_dec;
   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]      wr_idx;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] wr_data, merged;
   logic [STRB_W-1:0]     wr_strb;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  unused_prot;

   assign unused_prot = ^{i_s_axi_awprot, i_s_axi_arprot};

   axil_addr_check #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .BASE_ADDR (BASE_ADDR)
   ) u_aw_check (
      .addr    (i_s_axi_awaddr),
      .idx     (aw_idx_dec),
      .in_range(aw_ok_dec)
   );

   axil_addr_check #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .BASE_ADDR (BASE_ADDR)
   ) u_ar_check (
      .addr    (i_s_axi_araddr),
      .idx     (ar_idx_dec),
      .in_range(ar_ok_dec)
   );

   // ready_en keeps every ready low until the first edge after reset release.
   assign o_s_axi_awready = ready_en && (w_state == W_IDLE) && !aw_held;
   assign o_s_axi_wready  = ready_en && (w_state == W_IDLE) && !w_held;
   assign o_s_axi_arready = ready_en && (r_state == R_IDLE);
   assign o_s_axi_bvalid  = (w_state == W_RESP);
   assign o_s_axi_rvalid  = (r_state == R_DATA);

   assign aw_hs  = i_s_axi_awvalid && o_s_axi_awready;
   assign w_hs   = i_s_axi_wvalid && o_s_axi_wready;
   assign ar_hs  = i_s_axi_arvalid && o_s_axi_arready;
   assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

   assign wr_idx  = aw_held ? aw_idx_q : aw_idx_dec;
   assign wr_ok   = aw_held ? aw_ok_q : aw_ok_dec;
   assign wr_data = w_held ? wdata_q : i_s_axi_wdata;
   assign wr_strb = w_held ? wstrb_q : i_s_axi_wstrb;

   always_comb begin
      merged = regs[wr_idx];
      for (int b = 0; b < STRB_W; b++) begin
         merged[b*8 +: 8] = merge_byte(regs[wr_idx][b*8 +: 8], wr_data[b*8 +: 8], wr_strb[b]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state  <= W_IDLE;
         r_state  <= R_IDLE;
         ready_en <= 1'b0;
      end else begin
         w_state  <= w_state_nxt;
         r_state  <= r_state_nxt;
         ready_en <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (commit) w_state_nxt = W_RESP;
         W_RESP:  if (i_s_axi_bready) w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
         R_DATA:  if (i_s_axi_rready) r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_idx_q      <= '0;
         aw_ok_q       <= 1'b0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         o_s_axi_bresp <= AXI_RESP_OKAY;
         o_wr_pulse    <= '0;
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      end else begin
         o_wr_pulse <= '0;
         if (commit) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            o_s_axi_bresp <= wr_ok ? AXI_RESP_OKAY : OOR_RESP;
            if (wr_ok) begin
               regs[wr_idx]       <= merged;
               o_wr_pulse[wr_idx] <= 1'b1;
            end
         end else begin
            if (aw_hs) begin
               aw_held  <= 1'b1;
               aw_idx_q <= aw_idx_dec;
               aw_ok_q  <= aw_ok_dec;
            end
            if (w_hs) begin
               w_held  <= 1'b1;
               wdata_q <= i_s_axi_wdata;
               wstrb_q <= i_s_axi_wstrb;
            end
         end
      end
   end

   // Nonblocking capture means a same-edge write is not yet visible here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_s_axi_rdata <= '0;
         o_s_axi_rresp <= AXI_RESP_OKAY;
      end else if (ar_hs) begin
         o_s_axi_rdata <= ar_ok_dec ? regs[ar_idx_dec] : '0;
         o_s_axi_rresp <= ar_ok_dec ? AXI_RESP_OKAY : OOR_RESP;
      end
   end

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_export
      assign o_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
   end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// tb/tb_axil_slave_regfile.sv - directed plus randomized checks of axil_slave_regfile against a register model
module tb_axil_slave_regfile;

   localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] OOR = 2'b10;
`else
   localparam logic [1:0] OOR = 2'b00;
`endif

   logic         clk;
   logic         reset_n;
   logic [31:0]  awaddr, wdata, araddr;
   logic [2:0]   awprot, arprot;
   logic [3:0]   wstrb;
   logic         awvalid, wvalid, bready, arvalid, rready;
   logic         awready, wready, bvalid, arready, rvalid;
   logic [1:0]   bresp, rresp;
   logic [31:0]  rdata;
   logic [255:0] regs;
   logic [7:0]   wr_pulse;

   int total = 0;
   int bad   = 0;
   logic [31:0] model [8];

   axil_slave_regfile dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_s_axi_awaddr (awaddr),
      .i_s_axi_awprot (awprot),
      .i_s_axi_awvalid(awvalid),
      .o_s_axi_awready(awready),
      .i_s_axi_wdata  (wdata),
      .i_s_axi_wstrb  (wstrb),
      .i_s_axi_wvalid (wvalid),
      .o_s_axi_wready (wready),
      .o_s_axi_bresp  (bresp),
      .o_s_axi_bvalid (bvalid),
      .i_s_axi_bready (bready),
      .i_s_axi_araddr (araddr),
      .i_s_axi_arprot (arprot),
      .i_s_axi_arvalid(arvalid),
      .o_s_axi_arready(arready),
      .o_s_axi_rdata  (rdata),
      .o_s_axi_rresp  (rresp),
      .o_s_axi_rvalid (rvalid),
      .i_s_axi_rready (rready),
      .o_regs         (regs),
      .o_wr_pulse     (wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      for (int k = 0; k < 8; k++) f[k*32 +: 32] = model[k];
      return f;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return (off < 32) ? model[off / 4] : 32'h0;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return (off < 32) ? 2'b00 : OOR;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int stall);
      int          n;
      logic        aw_acc, w_acc;
      logic [31:0] off;
      logic [7:0]  exp_pulse;
      off = addr - BASE;
      exp_pulse = 8'h00;
      if (off < 32) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[off / 4][8*b +: 8] = data[8*b +: 8];
         exp_pulse = 8'(1 << (off / 4));
      end
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      n = 0;
      while ((awvalid || wvalid) && n < 20) begin
         aw_acc = awvalid && awready;
         w_acc  = wvalid && wready;
         step();
         if (aw_acc) awvalid = 1'b0;
         if (w_acc)  wvalid  = 1'b0;
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_latency", 256'(n), 256'(1));
      check("bvalid_set", 256'(bvalid), 256'(1'b1));
      check("bresp", 256'(bresp), 256'(exp_resp(addr)));
      check("wr_pulse", 256'(wr_pulse), 256'(exp_pulse));
      check("regs_after_wr", regs, model_flat());
      for (int i = 0; i < stall; i++) begin
         step();
         check("bvalid_stall", 256'(bvalid), 256'(1'b1));
         check("bresp_stall", 256'(bresp), 256'(exp_resp(addr)));
         check("awready_stall", 256'(awready), 256'(1'b0));
         check("wready_stall", 256'(wready), 256'(1'b0));
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("bvalid_clr", 256'(bvalid), 256'(1'b0));
      check("wr_pulse_clr", 256'(wr_pulse), 256'(0));
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
      araddr = addr; arvalid = 1'b1; rready = 1'b0;
      check("arready", 256'(arready), 256'(1'b1));
      step();
      arvalid = 1'b0;
      check("rvalid_set", 256'(rvalid), 256'(1'b1));
      check("rdata", 256'(rdata), 256'(exp_d));
      check("rresp", 256'(rresp), 256'(exp_r));
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("rvalid_clr", 256'(rvalid), 256'(1'b0));
   endtask

   initial begin
      logic [31:0] a, d;
      logic [255:0] snap;
      reset_n = 1'b0;
      awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      for (int k = 0; k < 8; k++) model[k] = 32'h0;

      repeat (3) step();
      check("rst_awready", 256'(awready), 256'(1'b0));
      check("rst_wready", 256'(wready), 256'(1'b0));
      check("rst_arready", 256'(arready), 256'(1'b0));
      check("rst_valids", 256'({bvalid, rvalid}), 256'(0));
      check("rst_resps", 256'({bresp, rresp}), 256'(0));
      check("rst_rdata", 256'(rdata), 256'(0));
      check("rst_regs", regs, model_flat());
      check("rst_pulse", 256'(wr_pulse), 256'(0));
      reset_n = 1'b1;
      check("rel_awready_low", 256'(awready), 256'(1'b0));
      step();
      check("rel_readies", 256'({awready, wready, arready}), 256'(3'b111));

      axi_write(32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 0);
      axi_read(32'h0001_0004, 32'hDEAD_BEEF, 2'b00);

      // W beat two cycles ahead of AW
      axi_write(32'h0001_0008, 32'h1111_1111, 4'hF, 0);
      snap = model_flat();
      wdata = 32'h00AB_0000; wstrb = 4'b0100; wvalid = 1'b1;
      check("w_first_wready", 256'(wready), 256'(1'b1));
      step();
      wvalid = 1'b0;
      check("w_held_wready", 256'(wready), 256'(1'b0));
      check("w_held_nobvalid", 256'(bvalid), 256'(1'b0));
      step();
      check("w_held_wready2", 256'(wready), 256'(1'b0));
      check("w_held_nobvalid2", 256'(bvalid), 256'(1'b0));
      check("w_held_regs", regs, snap);
      awaddr = 32'h0001_0008; awvalid = 1'b1;
      check("aw_late_awready", 256'(awready), 256'(1'b1));
      step();
      awvalid = 1'b0;
      model[2] = 32'h11AB_1111;
      check("late_bvalid", 256'(bvalid), 256'(1'b1));
      check("late_pulse", 256'(wr_pulse), 256'(8'b0000_0100));
      check("late_merge", regs, model_flat());
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("late_bvalid_clr", 256'(bvalid), 256'(1'b0));

      axi_write(32'h0001_0010, 32'hCAFE_F00D, 4'hF, 5);

      snap = model_flat();
      axi_write(32'h0001_0020, 32'h5555_AAAA, 4'hF, 0);
      check("oor_regs_same", regs, snap);
      axi_read(32'h0001_0020, 32'h0, OOR);
      axi_write(32'h0000_FFFC, 32'h1234_5678, 4'hF, 0);

      // zero strobe: pulse fires, contents unchanged
      axi_write(32'h0001_0014, 32'hFFFF_FFFF, 4'h0, 0);

      // same-edge read and write to register 3
      axi_write(32'h0001_000C, 32'd5, 4'hF, 0);
      awaddr = 32'h0001_000C; wdata = 32'd9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h0001_000C; arvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      model[3] = 32'd9;
      check("same_rvalid", 256'(rvalid), 256'(1'b1));
      check("same_rdata_old", 256'(rdata), 256'(32'd5));
      check("same_bvalid", 256'(bvalid), 256'(1'b1));
      check("same_regs", regs, model_flat());
      bready = 1'b1; rready = 1'b1;
      step();
      bready = 1'b0; rready = 1'b0;
      check("same_valids_clr", 256'({bvalid, rvalid}), 256'(0));
      axi_read(32'h0001_000C, 32'd9, 2'b00);

      for (int i = 0; i < 24; i++) begin
         a = BASE + 32'($urandom_range(0, 9)) * 4 + 32'($urandom_range(0, 3));
         d = $urandom;
         axi_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
         a = BASE + 32'($urandom_range(0, 9)) * 4 + 32'($urandom_range(0, 3));
         axi_read(a, exp_rdata(a), exp_resp(a));
      end

      // reset while both FSMs are mid-response
      awaddr = 32'h0001_0000; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h0001_0004; arvalid = 1'b1;
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("pre_rst_valids", 256'({bvalid, rvalid}), 256'(2'b11));
      #2;
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) model[k] = 32'h0;
      check("async_rst_valids", 256'({bvalid, rvalid}), 256'(0));
      check("async_rst_regs", regs, model_flat());
      step();
      reset_n = 1'b1;
      step();
      check("post_rst_valids", 256'({bvalid, rvalid}), 256'(0));
      axi_write(32'h0001_001C, 32'h0BAD_CAFE, 4'hF, 0);
      axi_read(32'h0001_001C, 32'h0BAD_CAFE, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
